approx_mul_rr_sched: RTL and testbench



---
 rtl/approx_mul_pkg.sv | 40 ++++
 rtl/approx_mul_rr_sched_if.sv | 21 ++
 rtl/approx_mul8_l2_core.sv | 17 +
 rtl/approx_mul_rr_sched.sv | 111 +++++++++++
 tb/tb_approx_mul_rr_sched.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types, widths and round-robin pick helper for the approximate-multiplier
// scheduler family.
package approx_mul_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef struct packed {
    logic [OP_W-1:0]  x;
    logic [OP_W-1:0]  y;
    logic [IDX_W-1:0] id;
  } op_t;

  typedef struct packed {
    logic [PROD_W-1:0] z;
    logic [IDX_W-1:0]  id;
  } rsp_t;

  // First set bit of valid, scanning upward from ptr and wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int unsigned        n);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && (k < n) && valid[IDX_W'(idx)]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/approx_mul_rr_sched_if.sv
// Request/response bus of the shared approximate multiplier.
interface approx_mul_rr_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  import approx_mul_pkg::*;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [OP_W*N_REQ-1:0] req_x;
  logic [OP_W*N_REQ-1:0] req_y;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [PROD_W-1:0]     rsp_z;
  logic [ID_W-1:0]       rsp_id;

  modport master (output req_valid, req_x, req_y, rsp_ready,
                  input  req_ready, rsp_valid, rsp_z, rsp_id);
  modport slave  (input  req_valid, req_x, req_y, rsp_ready,
                  output req_ready, rsp_valid, rsp_z, rsp_id);
endinterface

// File: rtl/approx_mul8_l2_core.sv
// Combinational 8x8 unsigned approximate multiplier: X[1:0] partial products
// truncated except for the three terms feeding bits 7 and 8.
module approx_mul8_l2_core
  import approx_mul_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] z
);

  always_comb begin
    z = ((PROD_W'(y) * PROD_W'(x[7:2])) << 2)
      + (PROD_W'((x[0] & y[6]) | (x[1] & y[5])) << 7)
      + (PROD_W'(x[1] & y[7]) << 8);
  end

endmodule

// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler sharing one approximate multiplier across N_REQ requesters
// through an operand stage and a product stage. Optional APPROX_ERR_STAT_EN adds
// op/error statistics counters.
module approx_mul_rr_sched
  import approx_mul_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  approx_mul_rr_sched_if.slave  bus,
  output logic                  busy
`ifdef APPROX_ERR_STAT_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_err
`endif
);

  op_t              s1;
  logic             s1_valid;
  rsp_t             s2;
  logic             s2_valid;
  logic [IDX_W-1:0] ptr;

  logic               stall;
  logic               s1_open;
  logic               grant;
  logic [IDX_W-1:0]   gidx;
  logic [MAX_REQ-1:0] valid_ext;
  logic [OP_W-1:0]    gx;
  logic [OP_W-1:0]    gy;
  logic [PROD_W-1:0]  z;

  // Arbitration and operand mux; ready is suppressed while reset is asserted.
  always_comb begin
    valid_ext              = '0;
    valid_ext[N_REQ-1:0]   = bus.req_valid;
    stall                  = s2_valid & ~bus.rsp_ready;
    s1_open                = ~s1_valid | ~stall;
    gidx                   = rr_pick(valid_ext, ptr, N_REQ);
    grant                  = rst_n & s1_open & (|bus.req_valid);
    gx                     = '0;
    gy                     = '0;
    bus.req_ready          = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == gidx) begin
        gx               = bus.req_x[OP_W*i +: OP_W];
        gy               = bus.req_y[OP_W*i +: OP_W];
        bus.req_ready[i] = grant;
      end
    end
  end

  approx_mul8_l2_core u_core (
    .x (s1.x),
    .y (s1.y),
    .z (z)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= '0;
      s1_valid <= 1'b0;
      s2       <= '0;
      s2_valid <= 1'b0;
      ptr      <= '0;
    end else begin
      if (!stall) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2 <= '{z: z, id: s1.id};
      end
      if (grant) begin
        s1       <= '{x: gx, y: gy, id: gidx};
        s1_valid <= 1'b1;
        ptr      <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(gidx + 1'b1);
      end else if (!stall) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_z     = s2.z;
  assign bus.rsp_id    = ID_W'(s2.id);
  assign busy          = s1_valid | s2_valid;

`ifdef APPROX_ERR_STAT_EN
  logic [PROD_W-1:0] exact;
  logic              xfer;

  always_comb begin
    exact = PROD_W'(s1.x) * PROD_W'(s1.y);
    xfer  = s1_valid & ~stall;
  end

  // Clear wins over a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_ops <= '0;
      stat_err <= '0;
    end else if (xfer) begin
      stat_ops <= stat_ops + 32'd1;
      if (z != exact) stat_err <= stat_err + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_approx_mul_rr_sched.sv
// Randomized self-checking bench for approx_mul_rr_sched against an occupancy and
// scoreboard reference model.
module tb_approx_mul_rr_sched;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic busy;
`ifdef APPROX_ERR_STAT_EN
  logic        stat_clr;
  logic [31:0] stat_ops;
  logic [31:0] stat_err;
`endif

  approx_mul_rr_sched_if #(.N_REQ(4), .ID_W(2)) ifc ();

  approx_mul_rr_sched #(.N_REQ(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave),
    .busy  (busy)
`ifdef APPROX_ERR_STAT_EN
    ,
    .stat_clr (stat_clr),
    .stat_ops (stat_ops),
    .stat_err (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m1v = 0;
  bit m2v = 0;
  int m_ptr = 0;
  int acc_n = 0;
  int exp_z[$];
  int exp_id[$];
  int dlv_ids[$];

  function automatic int ref_z(int x, int y);
    int r;
    r = y * (x / 4) * 4;
    if (((x % 2 == 1) && ((y / 64) % 2 == 1)) || (((x / 2) % 2 == 1) && ((y / 32) % 2 == 1)))
      r = r + 128;
    if (((x / 2) % 2 == 1) && ((y / 128) % 2 == 1))
      r = r + 256;
    return r;
  endfunction

  // One clock cycle: check outputs, predict the grant, advance the model.
  task automatic step();
    int g;
    bit stall_m;
    bit open_m;
    logic [3:0] exp_ready;
    int ez;
    int eid;
    #1;
    stall_m = m2v && !ifc.rsp_ready;
    open_m  = !m1v || !stall_m;
    g = -1;
    if (rst_n && open_m)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && ifc.req_valid[i]) g = i;
      end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
    total++;
    if (ifc.req_ready !== exp_ready) begin
      bad++;
      $display("FAIL req_ready got=%b want=%b t=%0t", ifc.req_ready, exp_ready, $time);
    end
    total++;
    if (ifc.rsp_valid !== m2v) begin
      bad++;
      $display("FAIL rsp_valid got=%b want=%b t=%0t", ifc.rsp_valid, m2v, $time);
    end
    total++;
    if (busy !== (m1v | m2v)) begin
      bad++;
      $display("FAIL busy got=%b want=%b t=%0t", busy, (m1v | m2v), $time);
    end
    if (rst_n && m2v && ifc.rsp_ready) begin
      total++;
      if (exp_z.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected got_id=%0d want=none", ifc.rsp_id);
      end else begin
        ez  = exp_z.pop_front();
        eid = exp_id.pop_front();
        if (ifc.rsp_z !== 16'(ez) || ifc.rsp_id !== 2'(eid)) begin
          bad++;
          $display("FAIL rsp_data got=%0d/id%0d want=%0d/id%0d t=%0t",
                   ifc.rsp_z, ifc.rsp_id, ez, eid, $time);
        end
        dlv_ids.push_back(int'(ifc.rsp_id));
      end
    end
    if (g >= 0) begin
      exp_z.push_back(ref_z(int'(ifc.req_x[8*g +: 8]), int'(ifc.req_y[8*g +: 8])));
      exp_id.push_back(g);
      acc_n++;
    end
    if (!rst_n) begin
      m1v = 0; m2v = 0; m_ptr = 0;
      exp_z.delete(); exp_id.delete();
    end else begin
      if (!stall_m) m2v = m1v;
      if (g >= 0) begin
        m1v = 1;
        m_ptr = (g + 1) % N;
      end else if (!stall_m) begin
        m1v = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic randomize_ops();
    ifc.req_x = $urandom();
    ifc.req_y = $urandom();
  endtask

  task automatic drain();
    ifc.req_valid = '0;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 8 && (m1v || m2v); i++) step();
    total++;
    if (m1v || m2v || exp_z.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout left=%0d want=0", exp_z.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    #1;
    total++; if (ifc.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", ifc.rsp_valid); end
    total++; if (ifc.rsp_z !== 16'd0) begin bad++; $display("FAIL rst_rsp_z got=%0d want=0", ifc.rsp_z); end
    total++; if (ifc.rsp_id !== 2'd0) begin bad++; $display("FAIL rst_rsp_id got=%0d want=0", ifc.rsp_id); end
    total++; if (ifc.req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", ifc.req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic issue_one(int id, int x, int y, int zexp);
    randomize_ops();
    ifc.req_valid = 4'(1 << id);
    ifc.req_x[8*id +: 8] = 8'(x);
    ifc.req_y[8*id +: 8] = 8'(y);
    ifc.rsp_ready = 1'b1;
    step();
    ifc.req_valid = '0;
    step();
    #1;
    total++;
    if (ifc.rsp_valid !== 1'b1 || ifc.rsp_z !== 16'(zexp) || ifc.rsp_id !== 2'(id)) begin
      bad++;
      $display("FAIL directed_%0dx%0d got=v%b z%0d id%0d want=v1 z%0d id%0d",
               x, y, ifc.rsp_valid, ifc.rsp_z, ifc.rsp_id, zexp, id);
    end
    step();
  endtask

  task automatic test_directed();
    issue_one(0, 4, 5, 20);
    issue_one(1, 3, 128, 256);
    issue_one(2, 1, 64, 128);
    issue_one(3, 255, 255, 64644);
    drain();
  endtask

  task automatic test_back_to_back();
    dlv_ids.delete();
    ifc.req_valid = 4'hF;
    ifc.rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      randomize_ops();
      step();
    end
    total++;
    if (dlv_ids.size() != 14) begin
      bad++;
      $display("FAIL b2b_throughput got=%0d want=14", dlv_ids.size());
    end
    drain();
    for (int k = 0; k < dlv_ids.size(); k++) begin
      total++;
      if (dlv_ids[k] != k % N) begin
        bad++;
        $display("FAIL b2b_order[%0d] got=%0d want=%0d", k, dlv_ids[k], k % N);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] z0;
    logic [1:0]  id0;
    int          acc0;
    randomize_ops();
    ifc.req_valid = 4'b0001;
    ifc.rsp_ready = 1'b1;
    step();
    ifc.req_valid = '0;
    step();
    z0  = ifc.rsp_z;
    id0 = ifc.rsp_id;
    acc0 = acc_n;
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      randomize_ops();
      step();
      total++;
      if (ifc.rsp_z !== z0 || ifc.rsp_id !== id0 || ifc.rsp_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold got=z%0d id%0d want=z%0d id%0d", ifc.rsp_z, ifc.rsp_id, z0, id0);
      end
    end
    total++;
    if (acc_n - acc0 != 1) begin
      bad++;
      $display("FAIL stall_accepts got=%0d want=1", acc_n - acc0);
    end
    drain();
  endtask

  task automatic test_single();
    dlv_ids.delete();
    ifc.req_valid = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      randomize_ops();
      ifc.rsp_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();
    total++;
    if (dlv_ids.size() < 3) begin
      bad++;
      $display("FAIL single_count got=%0d want>=3", dlv_ids.size());
    end
    foreach (dlv_ids[k]) begin
      total++;
      if (dlv_ids[k] != 2) begin
        bad++;
        $display("FAIL single_id[%0d] got=%0d want=2", k, dlv_ids[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ifc.rsp_ready = 1'b0;
    ifc.req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      randomize_ops();
      step();
    end
    rst_n = 1'b0;
    step();
    #1;
    total++;
    if (ifc.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flush got=v%b busy%b want=v0 busy0", ifc.rsp_valid, busy);
    end
    rst_n = 1'b1;
    ifc.rsp_ready = 1'b1;
    ifc.req_valid = 4'b1100;
    #1;
    total++;
    if (ifc.req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL midrst_first_grant got=%b want=0100", ifc.req_ready);
    end
    step();
    drain();
  endtask

`ifdef APPROX_ERR_STAT_EN
  task automatic test_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    issue_one(0, 4, 5, 20);
    issue_one(1, 3, 128, 256);
    issue_one(2, 1, 64, 128);
    drain();
    #1;
    total++;
    if (stat_ops !== 32'd3 || stat_err !== 32'd2) begin
      bad++;
      $display("FAIL stats got=ops%0d err%0d want=ops3 err2", stat_ops, stat_err);
    end
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    #1;
    total++;
    if (stat_ops !== 32'd0 || stat_err !== 32'd0) begin
      bad++;
      $display("FAIL stats_clr got=ops%0d err%0d want=0", stat_ops, stat_err);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    ifc.req_valid = '0;
    ifc.req_x = '0;
    ifc.req_y = '0;
    ifc.rsp_ready = 1'b1;
`ifdef APPROX_ERR_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_single();
    test_reset_mid();
`ifdef APPROX_ERR_STAT_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
